mod_inv_binary: RTL

MOD_INV_BINARY -- requirements
Module: mod_inv_binary

---
 rtl/mod_arith_pkg.sv | 7 +
 rtl/mod_sub_module.sv | 11 +
 rtl/mod_inv_binary.sv | 84 ++++++++
 3 files changed

// File: rtl/mod_arith_pkg.sv
// mod_arith_pkg: shared FSM state encoding and latency bound for modular arithmetic blocks
package mod_arith_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  function automatic int lat_bound(input int w);
    return 4 * w + 2;
  endfunction
endpackage

// File: rtl/mod_sub_module.sv
// mod_sub_module: (a - b) mod n for 0 <= a, b < n
module mod_sub_module #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] r
);
  assign r = a - b + (a < b ? n : '0);
endmodule

// File: rtl/mod_inv_binary.sv
// mod_inv_binary: binary extended-GCD modular inverse, one reduction step per cycle
module mod_inv_binary
  import mod_arith_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] N,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] R
);
  state_t state_q;
  logic [WIDTH-1:0] u_q, v_q, x1_q, x2_q, n_q, r_q;
  logic [WIDTH-1:0] u_d, v_d, x1_d, x2_d, h1, h2, sub_r;
  logic [WIDTH:0] s1, s2;
  logic inv_q, busy_q, done_q, err_q, ge, stop_err;
  assign ge = u_q >= v_q;
  assign s1 = {1'b0, x1_q} + {1'b0, n_q};
  assign s2 = {1'b0, x2_q} + {1'b0, n_q};
  assign h1 = x1_q[0] ? s1[WIDTH:1] : x1_q >> 1;
  assign h2 = x2_q[0] ? s2[WIDTH:1] : x2_q >> 1;
  mod_sub_module #(.WIDTH(WIDTH)) u_sub (
    .a(ge ? x1_q : x2_q),
    .b(ge ? x2_q : x1_q),
    .n(n_q),
    .r(sub_r)
  );
  // one reduction step, priority: u even, v even, u>=v, else
  always_comb begin
    u_d  = !u_q[0] ? u_q >> 1 : (v_q[0] && ge) ? u_q - v_q : u_q;
    v_d  = !u_q[0] ? v_q : !v_q[0] ? v_q >> 1 : ge ? v_q : v_q - u_q;
    x1_d = !u_q[0] ? h1 : (v_q[0] && ge) ? sub_r : x1_q;
    x2_d = !u_q[0] ? x2_q : !v_q[0] ? h2 : ge ? x2_q : sub_r;
  end
  assign stop_err = inv_q || u_q == '0 || v_q == '0;
  // control FSM with registered outputs and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      {u_q, v_q, x1_q, x2_q, n_q, r_q} <= '0;
      {inv_q, busy_q, done_q, err_q} <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          u_q     <= A;
          v_q     <= N;
          x1_q    <= WIDTH'(1);
          x2_q    <= '0;
          n_q     <= N;
          inv_q   <= !N[0] || N <= WIDTH'(1) || A == '0 || A >= N;
          err_q   <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= RUN;
        end
        RUN: if (stop_err || u_q == WIDTH'(1) || v_q == WIDTH'(1)) begin
          err_q   <= stop_err;
          r_q     <= stop_err ? '0 : u_q == WIDTH'(1) ? x1_q : x2_q;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= FIN;
        end else begin
          u_q  <= u_d;
          v_q  <= v_d;
          x1_q <= x1_d;
          x2_q <= x2_d;
        end
        FIN: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
  assign R    = r_q;
endmodule
